// File: rtl/ddr4_cmd_sequencer.sv
// rtl/ddr4_cmd_sequencer.sv - single-rank, single-open-bank DDR4 command sequencer
//
// Accepts one read/write request at a time and turns it into an ACT / RD|WR /
// PRE command stream, holding tRCD, CL and tRP spacing with wait counters.
// One bank is kept open after an access so that same-row requests skip the ACT.
//
// Ports:
//   ck_t, reset            clock (rising edge) and asynchronous active-high reset
//   req_valid/req_ready    request handshake; req_write, req_bg, req_ba,
//                          req_row, req_col describe the access
//   flush                  close the open row (honoured only while OPEN)
//   cs_n, act_n, A, bg, ba DDR4 command/address pins
//   sync                   per-bank open flag, index = bg*2**BAWIDTH+ba
//   wr_en, rd_en           write-data and read-data windows
//   busy                   high unless the sequencer is IDLE or OPEN
module ddr4_cmd_sequencer #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int BL        = 8,
  parameter int TRCD      = 15,
  parameter int TCL       = 10,
  parameter int TRP       = 10
) (
  input  logic                             ck_t,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [BGWIDTH-1:0]               req_bg,
  input  logic [BAWIDTH-1:0]               req_ba,
  input  logic [ADDRWIDTH-1:0]             req_row,
  input  logic [COLWIDTH-1:0]              req_col,
  input  logic                             flush,
  output logic                             cs_n,
  output logic                             act_n,
  output logic [ADDRWIDTH-1:0]             A,
  output logic [BGWIDTH-1:0]               bg,
  output logic [BAWIDTH-1:0]               ba,
  output logic [2**(BGWIDTH+BAWIDTH)-1:0]  sync,
  output logic                             wr_en,
  output logic                             rd_en,
  output logic                             busy
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_ACT    = 4'd1;
  localparam logic [3:0] S_TRCD_W = 4'd2;
  localparam logic [3:0] S_CMD    = 4'd3;
  localparam logic [3:0] S_WDATA  = 4'd4;
  localparam logic [3:0] S_RWAIT  = 4'd5;
  localparam logic [3:0] S_RDATA  = 4'd6;
  localparam logic [3:0] S_OPEN   = 4'd7;
  localparam logic [3:0] S_PRE    = 4'd8;
  localparam logic [3:0] S_TRP_W  = 4'd9;

  localparam int MAX_A = (TRCD > TCL) ? TRCD : TCL;
  localparam int MAX_B = (TRP > BL) ? TRP : BL;
  localparam int MAX_W = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_W + 1);

  logic [3:0]           state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;

  // Latest accepted request; on a miss it waits here while the old row closes.
  logic                 p_write;
  logic [BGWIDTH-1:0]   p_bg;
  logic [BAWIDTH-1:0]   p_ba;
  logic [ADDRWIDTH-1:0] p_row;
  logic [COLWIDTH-1:0]  p_col;

  // Currently open (or being opened) bank/row; PRE must address this one.
  logic [BGWIDTH-1:0]   cur_bg;
  logic [BAWIDTH-1:0]   cur_ba;
  logic [ADDRWIDTH-1:0] cur_row;

  // Set when a PRE was caused by a miss, so TRP_W continues to ACT not IDLE.
  logic                 reopen;

  logic accept, hit, bank_open;

  assign req_ready = !reset && !flush && (state == S_IDLE || state == S_OPEN);
  assign accept    = req_valid && req_ready;
  assign hit       = (req_bg == cur_bg) && (req_ba == cur_ba) && (req_row == cur_row);
  assign cs_n      = reset;
  assign busy      = (state != S_IDLE) && (state != S_OPEN);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt != '0) ? cnt - 1'b1 : cnt;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_ACT;
      S_ACT: begin
        state_nxt = S_TRCD_W;
        cnt_nxt   = CW'(TRCD - 2);
      end
      S_TRCD_W: if (cnt == '0) state_nxt = S_CMD;
      S_CMD: begin
        if (p_write) begin
          state_nxt = S_WDATA;
          cnt_nxt   = CW'(BL - 2);
        end else begin
          state_nxt = S_RWAIT;
          cnt_nxt   = CW'(TCL - 2);
        end
      end
      S_WDATA:  if (cnt == '0) state_nxt = S_OPEN;
      S_RWAIT: begin
        if (cnt == '0) begin
          state_nxt = S_RDATA;
          cnt_nxt   = CW'(BL - 1);
        end
      end
      S_RDATA:  if (cnt == '0) state_nxt = S_OPEN;
      S_OPEN: begin
        if (flush)       state_nxt = S_PRE;
        else if (accept) state_nxt = hit ? S_CMD : S_PRE;
      end
      S_PRE: begin
        state_nxt = S_TRP_W;
        cnt_nxt   = CW'(TRP - 2);
      end
      S_TRP_W:  if (cnt == '0) state_nxt = reopen ? S_ACT : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ck_t or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      p_write <= 1'b0;
      p_bg    <= '0;
      p_ba    <= '0;
      p_row   <= '0;
      p_col   <= '0;
      cur_bg  <= '0;
      cur_ba  <= '0;
      cur_row <= '0;
      reopen  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        p_write <= req_write;
        p_bg    <= req_bg;
        p_ba    <= req_ba;
        p_row   <= req_row;
        p_col   <= req_col;
      end
      if (accept && state == S_IDLE) begin
        cur_bg  <= req_bg;
        cur_ba  <= req_ba;
        cur_row <= req_row;
      end
      if (state == S_TRP_W && cnt == '0 && reopen) begin
        cur_bg  <= p_bg;
        cur_ba  <= p_ba;
        cur_row <= p_row;
      end
      if (state == S_OPEN) begin
        if (flush)              reopen <= 1'b0;
        else if (accept && !hit) reopen <= 1'b1;
      end
    end
  end

  // The open flag is visible from the ACT cycle itself and drops in the PRE cycle.
  assign bank_open = (state != S_IDLE) && (state != S_PRE) && (state != S_TRP_W);

  always_comb begin
    sync = '0;
    if (bank_open) sync[{cur_bg, cur_ba}] = 1'b1;
  end

  always_comb begin
    act_n = 1'b1;
    A     = '0;
    bg    = '0;
    ba    = '0;
    case (state)
      S_ACT: begin
        act_n = 1'b0;
        A     = cur_row;
        bg    = cur_bg;
        ba    = cur_ba;
      end
      S_CMD: begin
        A[ADDRWIDTH-1 -: 3] = p_write ? 3'b100 : 3'b101;
        A[COLWIDTH-1:0]     = p_col;
        bg                  = cur_bg;
        ba                  = cur_ba;
      end
      S_PRE: begin
        A[ADDRWIDTH-1 -: 3] = 3'b010;
        bg                  = cur_bg;
        ba                  = cur_ba;
      end
      default: ;
    endcase
  end

  assign wr_en = (state == S_WDATA) || (state == S_CMD && p_write);
  assign rd_en = (state == S_RDATA);

endmodule

// File: doc/ddr4_cmd_sequencer.md
DDR4_CMD_SEQUENCER -- requirements
Module: ddr4_cmd_sequencer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- BGWIDTH, 2, bank-group address bits.
- BAWIDTH, 2, bank address bits.
- ADDRWIDTH, 17, row/command address bits.
- COLWIDTH, 10, column bits.
- BL, 8, burst length in ck_t cycles.
- TRCD, 15, ACT-to-column-command cycles.
- TCL, 10, RD-to-first-read-data cycles.
- TRP, 10, PRE-to-ACT cycles.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 Ports, one per line (name, direction, width, meaning); clock and reset first:
- ck_t, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous active-high reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, request can be accepted.
- req_write, in, 1, 1 = write, 0 = read.
- req_bg, in, BGWIDTH, target bank group.
- req_ba, in, BAWIDTH, target bank.
- req_row, in, ADDRWIDTH, target row.
- req_col, in, COLWIDTH, target column.
- flush, in, 1, close the open row.
- cs_n, out, 1, rank select (active low).
- act_n, out, 1, ACT strobe (active low).
- A, out, ADDRWIDTH, row, or command bits plus column.
- bg, out, BGWIDTH, bank group to the DIMM.
- ba, out, BAWIDTH, bank to the DIMM.
- sync, out, 2**(BGWIDTH+BAWIDTH), per-bank open flag; index = bg*2**BAWIDTH+ba.
- wr_en, out, 1, write-data window.
- rd_en, out, 1, read-data window.
- busy, out, 1, state is not IDLE or OPEN.

Function
REQ-004 States: IDLE, ACT, TRCD_W, CMD, WDATA, RWAIT, RDATA, OPEN, PRE, TRP_W.
REQ-005 req_ready shall be 1 only in IDLE or OPEN with flush=0.
REQ-006 A request is accepted on a rising edge with req_valid & req_ready; all req_* fields are registered at that edge.
REQ-007 IDLE + accept -> ACT in the next cycle.
REQ-008 ACT cycle:
- act_n=0, A=row, bg/ba = target bank.
- sync[target] set in the same cycle.
- Next state TRCD_W.
REQ-009 TRCD_W shall hold TRCD-1 cycles, so the column command falls exactly TRCD cycles after ACT.
REQ-010 CMD cycle:
- A[16:14]=100 for WR, 101 for RD; A[COLWIDTH-1:0]=col; remaining A bits 0.
- bg/ba = target.
REQ-011 Write: wr_en=1 from the CMD cycle for BL cycles (CMD+WDATA), then OPEN.
REQ-012 Read: rd_en=0 for TCL cycles after CMD (RWAIT), then 1 for BL cycles (RDATA), then OPEN.
REQ-013 OPEN + accept:
- Same bank and row (hit) -> CMD next cycle, no ACT.
- Different bank or row (miss) -> PRE of the open bank, then TRP_W, then ACT of the new request.
REQ-014 OPEN + flush=1 -> PRE, then TRP_W, then IDLE; flush in IDLE has no effect.
REQ-015 PRE cycle:
- A[16:14]=010, all other A bits 0, bg/ba = open bank.
- sync[open bank] cleared in the same cycle.
REQ-016 TRP_W shall hold TRP-1 cycles, so the next ACT falls exactly TRP cycles after PRE.
REQ-017 Non-command cycles (outside ACT, CMD, PRE): act_n=1, A=0, bg=0, ba=0.
REQ-018 cs_n=0 in every cycle after reset deasserts.
REQ-019 At most one bank is open; sync shall be one-hot or zero.
REQ-020 req_valid with req_ready=0 shall be ignored; no internal queue.
REQ-021 Wait and burst counters shall be wide enough for max(TRCD, TCL, TRP, BL) and reload on each state entry; no wrap.

Reset
REQ-022 reset=1, asynchronously:
- Outputs: cs_n=1, act_n=1, A=0, bg=0, ba=0, sync=0, wr_en=0, rd_en=0, busy=0, req_ready=0.
- State IDLE; captured request discarded.
REQ-023 Reset mid-burst shall drop the burst with no PRE issued; after release the block starts from IDLE with req_ready=1.

Verification
REQ-024 Write to bg=1, ba=1, row=1, col=2, accepted at cycle 0:
- ACT at cycle 1: A=0x00001, sync[5]=1.
- WR at cycle 16: A=0x10002.
- wr_en high cycles 16-23; OPEN at 24.
REQ-025 Read hit, same bank and row 1, col=2, accepted in OPEN at cycle c:
- RD at c+1: A=0x14002, no ACT.
- rd_en high c+11 to c+18.
REQ-026 Miss, row=4 same bank, accepted in OPEN at c:
- PRE at c+1: A=0x08000, bg=1, ba=1, sync=0.
- ACT at c+11: A=0x00004, sync[5]=1.
REQ-027 flush in OPEN at c:
- PRE at c+1; IDLE at c+11; req_ready=1 from c+11.
REQ-028 req_valid held high during a burst: req_ready=0, no extra command; accepted on the first cycle of OPEN.
REQ-029 reset asserted during cycle 3 of wr_en: all outputs to reset values without waiting for a clock edge; after release a new write produces ACT with correct timing.
